// File: rtl/matmul_pkg.sv
// Shared types for the matrix-multiply sequencer:
// controller states, operand dimensions and a power-of-two modulo helper.
package matmul_pkg;

  localparam int DIM_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    START,
    RUN,
    DRAIN,
    FINISH
  } ctrl_state_t;

  typedef struct packed {
    logic [DIM_W-1:0] m;
    logic [DIM_W-1:0] n;
    logic [DIM_W-1:0] p;
  } mm_dims_t;

  // pow2 is a power of two, so the modulo is a low-bit mask
  function automatic logic is_mult(
    input logic [DIM_W-1:0] v,
    input int unsigned      pow2
  );
    return (v & DIM_W'(pow2 - 1)) == '0;
  endfunction

endpackage

// File: rtl/matmul_controller_if.sv
// Dimension command handshake between the config
// module (master) and the matmul controller (slave).
interface matmul_controller_if;
  import matmul_pkg::*;

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [DIM_W-1:0] cfg_m_i;
  logic [DIM_W-1:0] cfg_n_i;
  logic [DIM_W-1:0] cfg_p_i;

  modport master (
    output cfg_valid_i,
    output cfg_m_i,
    output cfg_n_i,
    output cfg_p_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_m_i,
    input  cfg_n_i,
    input  cfg_p_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/mm_dim_checker.sv
// Combinational check that a dimension command maps onto
// the systolic array: all dims non-zero, m and p tile-aligned.
module mm_dim_checker
  import matmul_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4
) (
  input  mm_dims_t i_dims,
  output logic     o_valid
);

  logic w_nonzero;
  logic w_aligned;

  assign w_nonzero = (i_dims.m != '0)
                  && (i_dims.n != '0)
                  && (i_dims.p != '0);

  assign w_aligned = is_mult(i_dims.m, ARRAY_HEIGHT)
                  && is_mult(i_dims.p, ARRAY_WIDTH);

  assign o_valid = w_nonzero && w_aligned;

endmodule

// File: rtl/matmul_controller.sv
// Sequencer for one C = A * B pass: validate, start the
// address generators, run, drain the array, report done.
module matmul_controller
  import matmul_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int DRAIN_CYCLES = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int PERF_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  matmul_controller_if.slave    cfg,
  input  logic                  abort_i,
  output logic [DIM_W-1:0]      m_o,
  output logic [DIM_W-1:0]      n_o,
  output logic [DIM_W-1:0]      p_o,
  output logic                  gen_start_o,
  input  logic                  a_done_i,
  input  logic                  b_done_i,
  output logic                  array_clear_o,
  output logic                  array_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [PERF_WIDTH-1:0] perf_cycles_o
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD =
    DCW'(DRAIN_CYCLES - 1);
  localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

  ctrl_state_t           r_state;
  ctrl_state_t           w_next;
  mm_dims_t              r_dims;
  logic                  r_a_seen;
  logic                  r_b_seen;
  logic [PERF_WIDTH-1:0] r_cnt;
  logic [PERF_WIDTH-1:0] r_perf;
  logic [DCW-1:0]        r_drain;

  logic                  w_accept;
  logic                  w_abort;
  logic                  w_dims_ok;
  logic                  w_both_done;
  logic [PERF_WIDTH-1:0] w_cnt_inc;

  mm_dim_checker #(
    .ARRAY_HEIGHT(ARRAY_HEIGHT),
    .ARRAY_WIDTH (ARRAY_WIDTH)
  ) u_chk (
    .i_dims (r_dims),
    .o_valid(w_dims_ok)
  );

  assign w_accept = cfg.cfg_valid_i && (r_state == IDLE);
  assign w_abort  = abort_i && (r_state != IDLE);

  assign w_both_done = (r_a_seen || a_done_i)
                    && (r_b_seen || b_done_i);

  assign w_cnt_inc = (r_cnt == PERF_MAX) ?
    r_cnt : r_cnt + PERF_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) w_next = CHECK;
        CHECK:   w_next = w_dims_ok ? START : IDLE;
        START:   w_next = RUN;
        RUN:     if (w_both_done) w_next = DRAIN;
        DRAIN:   if (r_drain == '0) w_next = FINISH;
        FINISH:  w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // done_o and err_o are gated by abort in the same cycle
  always_comb begin
    cfg.cfg_ready_o = 1'b0;
    gen_start_o     = 1'b0;
    array_clear_o   = 1'b0;
    array_en_o      = 1'b0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    unique case (r_state)
      IDLE:  cfg.cfg_ready_o = 1'b1;
      CHECK: err_o = !w_dims_ok && !abort_i;
      START: begin
        gen_start_o   = 1'b1;
        array_clear_o = 1'b1;
      end
      RUN:    array_en_o = 1'b1;
      DRAIN:  array_en_o = 1'b1;
      FINISH: done_o = !abort_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dims   <= '0;
      r_a_seen <= 1'b0;
      r_b_seen <= 1'b0;
      r_cnt    <= '0;
      r_perf   <= '0;
      r_drain  <= '0;
    end else begin
      if (w_accept) begin
        r_dims <= '{m: cfg.cfg_m_i,
                    n: cfg.cfg_n_i,
                    p: cfg.cfg_p_i};
      end

      if (w_abort || r_state == START) begin
        r_a_seen <= 1'b0;
        r_b_seen <= 1'b0;
      end else if (r_state == RUN) begin
        if (a_done_i) r_a_seen <= 1'b1;
        if (b_done_i) r_b_seen <= 1'b1;
      end

      // counts START through the current cycle
      if (r_state == START) begin
        r_cnt <= PERF_WIDTH'(1);
      end else if (r_state == RUN || r_state == DRAIN) begin
        r_cnt <= w_cnt_inc;
      end

      if (r_state == RUN) begin
        r_drain <= DRAIN_LOAD;
      end else if (r_state == DRAIN && r_drain != '0) begin
        r_drain <= r_drain - DCW'(1);
      end

      if (r_state == FINISH && !abort_i) begin
        r_perf <= w_cnt_inc;
      end
    end
  end

  assign busy_o        = (r_state != IDLE);
  assign m_o           = r_dims.m;
  assign n_o           = r_dims.n;
  assign p_o           = r_dims.p;
  assign perf_cycles_o = r_perf;

endmodule

// File: tb/tb_matmul_controller.sv
// Self-checking bench for matmul_controller: directed and
// random commands against a cycle-timeline reference model.
module tb_matmul_controller;
  import matmul_pkg::*;

  localparam int AH = 4;
  localparam int AW = 4;
  localparam int DR = AH + AW;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic abort_i = 1'b0;
  logic a_done_i = 1'b0;
  logic b_done_i = 1'b0;
  logic [DIM_W-1:0] m_o, n_o, p_o;
  logic gen_start_o, array_clear_o, array_en_o;
  logic busy_o, done_o, err_o;
  logic [PW-1:0] perf_cycles_o;

  matmul_controller_if cfg();

  matmul_controller #(
    .ARRAY_HEIGHT(AH),
    .ARRAY_WIDTH (AW),
    .DRAIN_CYCLES(DR),
    .PERF_WIDTH  (PW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg          (cfg.slave),
    .abort_i      (abort_i),
    .m_o          (m_o),
    .n_o          (n_o),
    .p_o          (p_o),
    .gen_start_o  (gen_start_o),
    .a_done_i     (a_done_i),
    .b_done_i     (b_done_i),
    .array_clear_o(array_clear_o),
    .array_en_o   (array_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .perf_cycles_o(perf_cycles_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_perf = 0;

  int gs, gs_c, clr, en, dn, dn_c, er, er_c, rdy_c;
  logic [DIM_W-1:0] m_seen;

  function automatic bit ref_ok(input int m, n, p);
    return m != 0 && n != 0 && p != 0
        && (m % AH) == 0 && (p % AW) == 0;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (cfg.cfg_ready_o !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  // cycle c=1 is the cycle after acceptance; RUN cycle k is c=k+2
  task automatic drive_cmd(input int m, n, p, da, db, ab);
    wait_ready();
    cfg.cfg_valid_i = 1'b1;
    cfg.cfg_m_i = DIM_W'(m);
    cfg.cfg_n_i = DIM_W'(n);
    cfg.cfg_p_i = DIM_W'(p);
    @(posedge clk); #1;
    cfg.cfg_valid_i = 1'b0;
    gs = 0; gs_c = -1; clr = 0; en = 0;
    dn = 0; dn_c = -1; er = 0; er_c = -1; rdy_c = -1;
    m_seen = '0;
    for (int c = 1; c <= 300; c++) begin
      a_done_i = (c - 2 == da);
      b_done_i = (c - 2 == db);
      abort_i  = (c == ab);
      @(negedge clk);
      if (c == 1) m_seen = m_o;
      if (gen_start_o) begin gs++; gs_c = c; end
      if (array_clear_o) clr++;
      if (array_en_o) en++;
      if (done_o) begin dn++; dn_c = c; end
      if (err_o) begin er++; er_c = c; end
      if (cfg.cfg_ready_o) begin rdy_c = c; break; end
      @(posedge clk); #1;
    end
    a_done_i = 1'b0;
    b_done_i = 1'b0;
    abort_i  = 1'b0;
  endtask

  task automatic test_reset();
    cfg.cfg_valid_i = 1'b0;
    cfg.cfg_m_i = '0;
    cfg.cfg_n_i = '0;
    cfg.cfg_p_i = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({cfg.cfg_ready_o, busy_o, gen_start_o, array_clear_o,
         array_en_o, done_o, err_o} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 1000000",
        {cfg.cfg_ready_o, busy_o, gen_start_o, array_clear_o,
         array_en_o, done_o, err_o});
    end
    n_cmp++;
    if (perf_cycles_o !== '0 || m_o !== '0 ||
        n_o !== '0 || p_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data: perf %0d m %0d n %0d p %0d want 0",
        perf_cycles_o, m_o, n_o, p_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_perf = 0;
  endtask

  task automatic test_valid(input string nm,
                            input int m, n, p, da, db);
    int run;
    run = (da > db) ? da : db;
    drive_cmd(m, n, p, da, db, 0);
    n_cmp++;
    if (gs !== 1 || gs_c !== 2 || clr !== 1) begin
      n_bad++;
      $display("FAIL %s start: %0d pulses at %0d clr %0d, want 1 at 2 clr 1",
        nm, gs, gs_c, clr);
    end
    n_cmp++;
    if (en !== run + DR) begin
      n_bad++;
      $display("FAIL %s array_en: %0d cycles want %0d",
        nm, en, run + DR);
    end
    n_cmp++;
    if (dn !== 1 || dn_c !== run + DR + 3 || er !== 0) begin
      n_bad++;
      $display("FAIL %s done: %0d at %0d err %0d, want 1 at %0d err 0",
        nm, dn, dn_c, er, run + DR + 3);
    end
    n_cmp++;
    if (rdy_c !== run + DR + 4) begin
      n_bad++;
      $display("FAIL %s ready: at %0d want %0d",
        nm, rdy_c, run + DR + 4);
    end
    n_cmp++;
    if (perf_cycles_o !== PW'(run + DR + 2)) begin
      n_bad++;
      $display("FAIL %s perf: %0d want %0d",
        nm, perf_cycles_o, run + DR + 2);
    end
    n_cmp++;
    if (m_seen !== DIM_W'(m) || n_o !== DIM_W'(n) ||
        p_o !== DIM_W'(p)) begin
      n_bad++;
      $display("FAIL %s dims: %0d/%0d/%0d want %0d/%0d/%0d",
        nm, m_seen, n_o, p_o, m, n, p);
    end
    exp_perf = run + DR + 2;
  endtask

  task automatic test_invalid(input string nm, input int m, n, p);
    drive_cmd(m, n, p, 4, 4, 0);
    n_cmp++;
    if (er !== 1 || er_c !== 1) begin
      n_bad++;
      $display("FAIL %s err: %0d at %0d want 1 at 1", nm, er, er_c);
    end
    n_cmp++;
    if (gs !== 0 || en !== 0 || dn !== 0 || rdy_c !== 2) begin
      n_bad++;
      $display("FAIL %s flow: gs %0d en %0d dn %0d rdy %0d want 0 0 0 2",
        nm, gs, en, dn, rdy_c);
    end
    n_cmp++;
    if (perf_cycles_o !== PW'(exp_perf)) begin
      n_bad++;
      $display("FAIL %s perf: %0d want %0d",
        nm, perf_cycles_o, exp_perf);
    end
  endtask

  task automatic test_abort(input string nm, input int da, db, ab);
    drive_cmd(4, 4, 4, da, db, ab);
    n_cmp++;
    if (dn !== 0 || er !== 0) begin
      n_bad++;
      $display("FAIL %s pulses: done %0d err %0d want 0 0", nm, dn, er);
    end
    n_cmp++;
    if (rdy_c !== ab + 1) begin
      n_bad++;
      $display("FAIL %s idle: at %0d want %0d", nm, rdy_c, ab + 1);
    end
    n_cmp++;
    if (perf_cycles_o !== PW'(exp_perf)) begin
      n_bad++;
      $display("FAIL %s perf: %0d want %0d",
        nm, perf_cycles_o, exp_perf);
    end
  endtask

  task automatic test_idle_done();
    wait_ready();
    a_done_i = 1'b1;
    b_done_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_done_i = 1'b0;
    b_done_i = 1'b0;
    test_valid("idle_pulses", 8, 2, 4, 3, 6);
  endtask

  task automatic test_back_to_back();
    int dc;
    bit hold_bad;
    logic rdy_idle;
    logic [DIM_W-1:0] m2;
    logic busy2;
    dc = -1;
    hold_bad = 1'b0;
    rdy_idle = 1'b0;
    m2 = '0;
    busy2 = 1'b0;
    wait_ready();
    cfg.cfg_valid_i = 1'b1;
    cfg.cfg_m_i = 16'd8;
    cfg.cfg_n_i = 16'd3;
    cfg.cfg_p_i = 16'd4;
    @(posedge clk); #1;
    cfg.cfg_m_i = 16'd12;
    cfg.cfg_n_i = 16'd5;
    cfg.cfg_p_i = 16'd16;
    for (int c = 1; c <= 100; c++) begin
      a_done_i = (c - 2 == 5);
      b_done_i = (c - 2 == 5);
      @(negedge clk);
      if (done_o) dc = c;
      if (dc < 0 || c <= dc + 1) begin
        if (m_o !== 16'd8 || n_o !== 16'd3 || p_o !== 16'd4)
          hold_bad = 1'b1;
      end
      if (dc >= 0 && c == dc + 1) rdy_idle = cfg.cfg_ready_o;
      if (dc >= 0 && c == dc + 2) begin
        m2 = m_o;
        busy2 = busy_o;
        break;
      end
      @(posedge clk); #1;
    end
    a_done_i = 1'b0;
    b_done_i = 1'b0;
    cfg.cfg_valid_i = 1'b0;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    n_cmp++;
    if (dc !== 5 + DR + 3) begin
      n_bad++;
      $display("FAIL b2b_done: at %0d want %0d", dc, 5 + DR + 3);
    end
    n_cmp++;
    if (hold_bad !== 1'b0 || rdy_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold: dims_changed %0b idle_ready %0b want 0 1",
        hold_bad, rdy_idle);
    end
    n_cmp++;
    if (m2 !== 16'd12 || busy2 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: m %0d busy %0b want 12 1", m2, busy2);
    end
    exp_perf = 5 + DR + 2;
    n_cmp++;
    if (perf_cycles_o !== PW'(exp_perf) || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_abort: perf %0d busy %0b want %0d 0",
        perf_cycles_o, busy_o, exp_perf);
    end
  endtask

  task automatic test_random();
    int m, n, p, da, db;
    for (int i = 0; i < 12; i++) begin
      m = AH * $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) m += $urandom_range(1, AH - 1);
      n = $urandom_range(0, 9);
      p = AW * $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) p += $urandom_range(1, AW - 1);
      da = $urandom_range(1, 20);
      db = $urandom_range(1, 20);
      if (ref_ok(m, n, p)) test_valid("rand_ok", m, n, p, da, db);
      else test_invalid("rand_bad", m, n, p);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    cfg.cfg_valid_i = 1'b1;
    cfg.cfg_m_i = 16'd8;
    cfg.cfg_n_i = 16'd8;
    cfg.cfg_p_i = 16'd8;
    @(posedge clk); #1;
    cfg.cfg_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (array_en_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_run: array_en %0b want 1", array_en_o);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cfg.cfg_ready_o, busy_o, gen_start_o, array_clear_o,
         array_en_o, done_o, err_o} !== 7'b1000000 ||
        perf_cycles_o !== '0 || m_o !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: ctrl %b perf %0d m %0d want 1000000 0 0",
        {cfg.cfg_ready_o, busy_o, gen_start_o, array_clear_o,
         array_en_o, done_o, err_o}, perf_cycles_o, m_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_perf = 0;
  endtask

  initial begin
    test_reset();
    test_valid("basic", 8, 5, 8, 10, 10);
    test_invalid("m_mod", 6, 4, 8);
    test_invalid("n_zero", 8, 0, 8);
    test_invalid("p_mod", 4, 4, 6);
    test_invalid("m_zero", 0, 4, 4);
    test_valid("split_done", 4, 4, 4, 3, 7);
    test_valid("b_first", 4, 1, 4, 9, 2);
    test_valid("big_dims", 65532, 1, 65532, 2, 2);
    test_idle_done();
    test_abort("abort_run", 5, 5, 4);
    test_abort("abort_drain", 5, 5, 5 + 3 + 2);
    test_abort("abort_finish", 5, 5, 5 + DR + 3);
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_valid("after_reset", 4, 3, 8, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_controller.md
Name: matmul_controller

Overview:
- Top-level sequencer for one matrix multiply C[m x p] = A[m x n] * B[n x p] on the ARRAY_HEIGHT x ARRAY_WIDTH systolic array.
- Accepts a dimension command, validates it, and latches it for the A/B address generators.
- Fires their common start pulse, gates the array while operands stream, waits for both generators to finish, drains the pipeline, then reports done.
- Sits between the config module and the address generators/array.

Parameters:
- ARRAY_HEIGHT, 4, array rows; power of two >= 2.
- ARRAY_WIDTH, 4, array columns; power of two >= 2.
- DRAIN_CYCLES, ARRAY_HEIGHT+ARRAY_WIDTH, cycles array_en_o stays high after both generators report done.
- PERF_WIDTH, 32, width of the cycle counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  command valid.
- cfg_ready_o  out  1  controller can accept a command.
- cfg_m_i  in  16  rows of A.
- cfg_n_i  in  16  inner dimension.
- cfg_p_i  in  16  columns of B.
- abort_i  in  1  synchronous abort.
- m_o  out  16  latched m to generators.
- n_o  out  16  latched n to generators.
- p_o  out  16  latched p to generators.
- gen_start_o  out  1  one-cycle start pulse to A and B generators.
- a_done_i  in  1  A generator done pulse.
- b_done_i  in  1  B generator done pulse.
- array_clear_o  out  1  clear array accumulators.
- array_en_o  out  1  array compute enable.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle invalid-command pulse.
- perf_cycles_o  out  PERF_WIDTH  cycles of last run.

Behaviour:
- Reset values: all outputs 0 except cfg_ready_o=1. State IDLE, sticky flags cleared, perf_cycles_o=0, m_o/n_o/p_o=0.
- States: IDLE, CHECK, START, RUN, DRAIN, FINISH.
- cfg_ready_o=1 only in IDLE. busy_o = state != IDLE.
- IDLE:
  - On cfg_valid_i & cfg_ready_o, latch cfg_*_i into m_o/n_o/p_o and go to CHECK.
  - m_o/n_o/p_o hold their values until the next accepted command.
- CHECK (1 cycle):
  - Valid iff m != 0, n != 0, p != 0, m mod ARRAY_HEIGHT == 0, and p mod ARRAY_WIDTH == 0.
  - Modulo uses low-bit masks, no dividers.
  - Invalid: err_o=1 this cycle, next state IDLE, perf_cycles_o unchanged.
  - Valid: next state START.
- START (1 cycle):
  - gen_start_o=1 and array_clear_o=1.
  - Clear a_seen/b_seen, load perf counter with 1, go to RUN.
- RUN:
  - array_en_o=1; perf counter increments each cycle.
  - a_done_i sets a_seen; b_done_i sets b_seen. Done pulses can arrive on different cycles or the same cycle.
  - Leave to DRAIN in the cycle after (a_seen|a_done_i) & (b_seen|b_done_i) becomes true.
  - Done pulses outside RUN are ignored.
- DRAIN:
  - array_en_o=1; down-counter loaded with DRAIN_CYCLES-1 on entry.
  - Exit to FINISH when the counter is 0, giving exactly DRAIN_CYCLES cycles in DRAIN.
  - DRAIN_CYCLES=0 is not supported.
- FINISH (1 cycle):
  - done_o=1, array_en_o=0.
  - perf_cycles_o <= counter + 1, counting from the START cycle through the FINISH cycle inclusive.
  - Next state IDLE.
- Perf counter saturates at all-ones and does not wrap.
- abort_i:
  - Has priority over all other transitions in CHECK, START, RUN, DRAIN and FINISH.
  - Next state IDLE; no done_o, no err_o; perf_cycles_o unchanged; sticky flags cleared.
  - Ignored in IDLE.
  - Abort in FINISH suppresses that cycle's done_o (Mealy gate on done_o).
- Reset mid-operation returns everything to reset values immediately, with no residual pulses.
- cfg_valid_i while busy is not accepted; the holder keeps it asserted.
- gen_start_o, done_o and err_o are never high for more than one consecutive cycle.

Decomposition:
- Package matmul_pkg holds:
  - typedef enum logic [2:0] ctrl_state_t {IDLE, CHECK, START, RUN, DRAIN, FINISH}.
  - DIM_W = 16.
  - typedef struct packed mm_dims_t {m, n, p}.
- One natural sub-module: mm_dim_checker, combinational validity check parameterised by ARRAY_HEIGHT/ARRAY_WIDTH, reusable by the config module.

Test Plan:
- Reset, then cfg m=8,n=5,p=8 accepted; a_done at RUN cycle 10, b_done at cycle 10 -> gen_start_o one pulse; array_en_o for 10+8 cycles; done_o once; perf_cycles_o=1+10+8+1... checked equal to cycles from START through FINISH.
- m=6,n=4,p=8 (6 mod 4 != 0) -> err_o pulse the cycle after accept, no gen_start_o, cfg_ready_o=1 two cycles after accept.
- n=0 -> err_o.
- m=p=4 with a_done at RUN cycle 3 and b_done at cycle 7 -> DRAIN entered only after b_done, done_o still single.
- a_done and b_done pulses while IDLE -> ignored; next valid run waits for fresh pulses.
- abort_i during RUN, DRAIN and FINISH -> IDLE next cycle, done_o stays 0, perf_cycles_o retains the previous run's value.
- reset_n deasserted mid-RUN -> outputs return to reset values asynchronously.
- cfg_valid_i held high during a run -> second command accepted only in the first IDLE cycle after FINISH; m_o/n_o/p_o change only then.
